// File: rtl/nibble_ser_pkg.sv
// Shared types and helpers for the nibble serializer.
//   ser_state_e    : engine state (IDLE, SHIFT)
//   DEF_WIDTH/DEPTH: default frame length and FIFO depth
//   first_bit_idx(): index of the bit presented first in a frame
package nibble_ser_pkg;
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 2;

  function automatic int first_bit_idx(input int width, input bit msb_first);
    return msb_first ? width - 1 : 0;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
//   clk, reset : clock, async active-high reset (empties the FIFO)
//   push/wdata : write wdata at the tail (ignored when full)
//   pop/rdata  : rdata always shows the head; pop advances it (ignored when empty)
//   full/empty : status decoded from the registered pointers
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB distinguishes full from empty when the index bits match.
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage carries no reset; contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/nibble_serializer.sv
// Parallel-to-serial front end for a serial-in shift register.
//   clk, reset         : clock, async active-high reset (drops any partial word)
//   in_data/in_valid   : word input, accepted when in_ready
//   in_ready           : FIFO not full
//   en                 : shift enable; 0 freezes the engine, pushes still land
//   ser_out/ser_valid  : serial bit and its qualifier
//   word_done          : last bit of a word is on ser_out
//   busy               : FIFO non-empty or engine shifting
module nibble_serializer
  import nibble_ser_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);
  localparam int            CW    = $clog2(WIDTH);
  localparam int            FIRST = first_bit_idx(WIDTH, MSB_FIRST);
  localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);

  ser_state_e       state;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic             push, pop, last;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign last     = (state == SHIFT) && (bit_cnt == LAST);
  // Load on the idle->shift transition or straight after a last bit, so
  // consecutive words stream without a bubble.
  assign pop      = en && !fifo_empty && ((state == IDLE) || last);

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Outputs decode registered state only; reset clears them asynchronously.
  assign ser_valid = (state == SHIFT);
  assign ser_out   = (state == SHIFT) && shift_reg[FIRST];
  assign word_done = last;
  assign busy      = (state == SHIFT) || !fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (en) begin
      if (pop) begin
        state     <= SHIFT;
        shift_reg <= fifo_rdata;
        bit_cnt   <= '0;
      end else if (last) begin
        state     <= IDLE;
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else if (state == SHIFT) begin
        // The next bit always moves into the FIRST position.
        shift_reg <= MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
        bit_cnt   <= bit_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_nibble_serializer.sv
module tb_nibble_serializer;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_data;
  logic       in_valid, en;
  logic       in_ready, ser_out, ser_valid, word_done, busy;

  int checks = 0;
  int errors = 0;

  nibble_serializer #(.WIDTH(4), .DEPTH(2), .MSB_FIRST(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .en        (en),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .word_done (word_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // One row: inputs held across an edge, outputs expected #1 after it.
  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       en;
    logic [4:0] exp; // {ser_out, ser_valid, word_done, in_ready, busy}
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic v, input logic [3:0] d, input logic e,
                     input logic so, input logic sv, input logic wd,
                     input logic rdy, input logic bsy);
    vec_t r;
    r.v = v; r.d = d; r.en = e; r.exp = {so, sv, wd, rdy, bsy};
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {so,sv,wd,rdy,busy}=%b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {ser_out, ser_valid, word_done, in_ready, busy};
  endfunction

  task automatic cyc(input logic v, input logic [3:0] d, input logic e);
    @(negedge clk);
    in_valid = v; in_data = d; en = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; en = 1'b1;
    #1 chk("reset_t1", outs(), 5'b00010);
    #8 chk("reset_t9", outs(), 5'b00010);
    @(negedge clk); reset = 1'b0;
    #1 chk("idle_after_reset", outs(), 5'b00010);

    // single word 1011
    add(1, 4'b1011, 1, 0,0,0,1,1);
    add(0, 0, 1, 1,1,0,1,1);
    add(0, 0, 1, 0,1,0,1,1);
    add(0, 0, 1, 1,1,0,1,1);
    add(0, 0, 1, 1,1,1,1,1);
    add(0, 0, 1, 0,0,0,1,0);
    // back-to-back 1100, 0110
    add(1, 4'b1100, 1, 0,0,0,1,1);
    add(1, 4'b0110, 1, 1,1,0,1,1);
    add(0, 0, 1, 1,1,0,1,1);
    add(0, 0, 1, 0,1,0,1,1);
    add(0, 0, 1, 0,1,1,1,1);
    add(0, 0, 1, 0,1,0,1,1);
    add(0, 0, 1, 1,1,0,1,1);
    add(0, 0, 1, 1,1,0,1,1);
    add(0, 0, 1, 0,1,1,1,1);
    add(0, 0, 1, 0,0,0,1,0);
    // full / backpressure: A, 5 accepted, F dropped
    add(1, 4'hA, 0, 0,0,0,1,1);
    add(1, 4'h5, 0, 0,0,0,0,1);
    add(1, 4'hF, 0, 0,0,0,0,1);
    add(0, 0, 1, 1,1,0,1,1);
    add(0, 0, 1, 0,1,0,1,1);
    add(0, 0, 1, 1,1,0,1,1);
    add(0, 0, 1, 0,1,1,1,1);
    add(0, 0, 1, 0,1,0,1,1);
    add(0, 0, 1, 1,1,0,1,1);
    add(0, 0, 1, 0,1,0,1,1);
    add(0, 0, 1, 1,1,1,1,1);
    add(0, 0, 1, 0,0,0,1,0);
    // stall mid-word 1001 after the 2nd bit
    add(1, 4'b1001, 1, 0,0,0,1,1);
    add(0, 0, 1, 1,1,0,1,1);
    add(0, 0, 1, 0,1,0,1,1);
    add(0, 0, 0, 0,1,0,1,1);
    add(0, 0, 0, 0,1,0,1,1);
    add(0, 0, 0, 0,1,0,1,1);
    add(0, 0, 1, 0,1,0,1,1);
    add(0, 0, 1, 1,1,1,1,1);
    add(0, 0, 1, 0,0,0,1,0);
    // stall on the last bit: word_done holds
    add(1, 4'b0011, 1, 0,0,0,1,1);
    add(0, 0, 1, 0,1,0,1,1);
    add(0, 0, 1, 0,1,0,1,1);
    add(0, 0, 1, 1,1,0,1,1);
    add(0, 0, 1, 1,1,1,1,1);
    add(0, 0, 0, 1,1,1,1,1);
    add(0, 0, 0, 1,1,1,1,1);
    add(0, 0, 1, 0,0,0,1,0);

    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].en);
      chk($sformatf("row%0d", i), outs(), tbl[i].exp);
    end

    // reset during 3rd bit of 1110 with 0001 queued
    cyc(1, 4'b1110, 1);
    cyc(1, 4'b0001, 1);
    chk("rst_bit1", outs(), 5'b11011);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("rst_bit3", outs(), 5'b11011);
    #2 reset = 1'b1;
    #1 chk("rst_async", outs(), 5'b00010);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1);
      chk($sformatf("rst_quiet%0d", i), outs(), 5'b00010);
    end
    // fresh word after reset: first bit one edge after the push
    cyc(1, 4'b0110, 1);
    chk("post_rst_push", outs(), 5'b00011);
    cyc(0, 0, 1);
    chk("post_rst_b1", outs(), 5'b01011);
    cyc(0, 0, 1);
    chk("post_rst_b2", outs(), 5'b11011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
